regfile_scan_reader: RTL and testbench
======================================

Name: regfile_scan_reader

Overview:
Read-side client for the 32x64 register file. On a start pulse it drives the register file's read-address port across a register range and streams each value out on a valid/ready interface, one register per cycle when unstalled. Used for debug dumps, context save and verification checkpoints. It shares one read port with the pipeline through an external mux and has no write path.

Parameters:
FIRST_REG, 0, first register index scanned (0..31).
LAST_REG, 31, last register index scanned; FIRST_REG <= LAST_REG is required, otherwise elaboration error.
FORCE_ZERO_X31, 1, when 1, index 31 is emitted as 64'h0 regardless of ReadData.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin a scan; ignored while busy=1.
abort  input  1  terminates the scan at the next edge.
ReadRegister  output  5  read address to the register file (combinational read).
ReadData  input  64  register file read data for ReadRegister, same cycle.
out_valid  output  1  out_data, out_index and out_last are valid.
out_ready  input  1  consumer accepts the beat when out_valid=1.
out_data  output  64  register value.
out_index  output  5  register index of out_data.
out_last  output  1  beat is register LAST_REG.
busy  output  1  active OR out_valid.
done  output  1  one-cycle pulse after the last beat handshakes.

Behaviour:
- Reset (reset=0, asynchronous): active=0, ptr=FIRST_REG, out_valid=0, out_data=0, out_index=0, out_last=0, done=0. ReadRegister=FIRST_REG.
- ReadRegister is driven directly from the ptr register, with no combinational path from inputs.
- Start: if busy=0 and start=1, then active<=1 and ptr<=FIRST_REG. The first beat is loaded on the next edge, so out_valid rises 2 cycles after start.
- Load condition: active=1 and (out_valid=0 or out_ready=1). On load:
  - out_data<=ReadData, or 0 if FORCE_ZERO_X31 and ptr==31.
  - out_index<=ptr.
  - out_last<=(ptr==LAST_REG).
  - out_valid<=1.
  - If ptr==LAST_REG, active<=0 and ptr<=FIRST_REG; otherwise ptr<=ptr+1.
- Drain: if not loading and out_valid=1 and out_ready=1, then out_valid<=0.
- Stall: while out_valid=1 and out_ready=0, out_data, out_index, out_last and ptr hold. No beat is dropped or duplicated.
- Throughput: with out_ready held at 1, one beat per cycle. The number of beats is LAST_REG-FIRST_REG+1.
- done: registered pulse, high for exactly the one cycle after the handshake of the beat with out_last=1.
- Wrap: ptr never increments past LAST_REG. With LAST_REG=31, no 5-bit overflow occurs.
- Single-register range (FIRST_REG==LAST_REG): exactly one beat, with out_last=1.
- Abort: at the next edge, active<=0, out_valid<=0 and ptr<=FIRST_REG. done is not asserted. abort overrides a simultaneous start or load.
- start and the final handshake in the same cycle: busy is still 1 in that cycle, so start is ignored.
- Concurrent writes: each value reflects the register file contents in its load cycle. No snapshot semantics.
- Reset mid-scan returns to the reset state immediately. No partial done.

Test Plan:
1. Full scan: Xn = 64'h1000+n; pulse start with out_ready=1 -> 32 consecutive beats, index 0..31; data 64'h1000..64'h101E for index 0..30; index 31 data 0; out_last on index 31 only; done one cycle after it.
2. Backpressure: out_ready toggles 1,0,0,1 repeating -> beats in order with no drops or duplicates; data stable while stalled; ReadRegister holds.
3. Sub-range with FIRST_REG=5, LAST_REG=7 -> exactly 3 beats, indices 5, 6, 7; out_last on 7; busy falls the cycle after the beat-7 handshake.
4. Abort at beat 10 (out_valid=1, out_ready=0) -> next cycle out_valid=0, busy=0, done never pulses; a subsequent start rescans from FIRST_REG.
5. Start while busy, plus start coincident with the final handshake -> both ignored; exactly one done pulse.
6. Async reset driven low mid-scan between clock edges -> out_valid and busy go 0 immediately; after release, idle until start.

Source files
------------

// File: rtl/regfile_scan_reader_if.sv
// Output stream of the register-file scan reader: one register value per beat,
// tagged with its index and an end-of-range marker, under valid/ready flow control.
interface regfile_scan_reader_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_scan_reader.sv
// Read-side scan client for the 32x64 register file. After a start pulse it walks
// the read-address port from FIRST_REG to LAST_REG and streams each value out,
// one beat per cycle when the consumer keeps out_ready high.
module regfile_scan_reader #(
  parameter int FIRST_REG      = 0,
  parameter int LAST_REG       = 31,
  parameter bit FORCE_ZERO_X31 = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  output logic [4:0]                   ReadRegister,
  input  logic [63:0]                  ReadData,
  regfile_scan_reader_if.master        out_if,
  output logic                         busy,
  output logic                         done
);

  if (FIRST_REG < 0 || LAST_REG > 31 || FIRST_REG > LAST_REG) begin : g_bad_range
    $error("regfile_scan_reader: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  // ST_SCAN is the "active" phase: the pointer still has registers left to load.
  // A final beat may still be waiting in the output register after leaving it.
  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] ptr;
  logic       active;
  logic       load;
  logic       drain;
  logic       start_go;
  logic       ptr_at_last;
  logic       zero_x31;

  // The pipeline shares this read port, so the address comes straight from a flop.
  assign ReadRegister = ptr;

  // Scan phase register; abort and reset both drop back to idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Leave idle on an accepted start, leave the scan once the last register is loaded.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_go) state_next = ST_SCAN;
        ST_SCAN: if (load && ptr_at_last) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Handshake decode: load whenever the output register is empty or being emptied.
  always_comb begin
    active      = (state == ST_SCAN);
    busy        = active || out_if.out_valid;
    load        = active && (!out_if.out_valid || out_if.out_ready);
    drain       = !load && out_if.out_valid && out_if.out_ready;
    start_go    = start && !busy;
    ptr_at_last = (ptr == LAST_IDX);
    zero_x31    = FORCE_ZERO_X31 && (ptr == 5'd31);
  end

  // Pointer, output beat register and the done pulse; abort wins over start and load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr              <= FIRST_IDX;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= 64'h0;
      out_if.out_index <= 5'd0;
      out_if.out_last  <= 1'b0;
      done             <= 1'b0;
    end else if (abort) begin
      ptr              <= FIRST_IDX;
      out_if.out_valid <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= out_if.out_valid && out_if.out_ready && out_if.out_last;
      if (start_go) begin
        ptr <= FIRST_IDX;
      end else if (load) begin
        ptr <= ptr_at_last ? FIRST_IDX : ptr + 5'd1;
      end
      if (load) begin
        out_if.out_valid <= 1'b1;
        out_if.out_data  <= zero_x31 ? 64'h0 : ReadData;
        out_if.out_index <= ptr;
        out_if.out_last  <= ptr_at_last;
      end else if (drain) begin
        out_if.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Scoreboard bench for regfile_scan_reader: a full-range instance and a 5..7
// sub-range instance read a shared register-file model; expected beats are queued
// by the stimulus and popped by negedge monitors on every handshake.
module tb_regfile_scan_reader;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  index;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub_start;
  logic        abort;
  logic        out_ready;
  logic [63:0] regs [32];
  logic [4:0]  rr;
  logic [4:0]  sub_rr;
  logic [63:0] rd;
  logic [63:0] sub_rd;
  logic        busy;
  logic        done;
  logic        sub_busy;
  logic        sub_done;

  beat_t q_main[$];
  beat_t q_sub[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int done_count   = 0;
  int sub_done_cnt = 0;
  int cyc          = 0;
  int ready_mode   = 0;
  logic [3:0] pat_bits = 4'b1001;

  regfile_scan_reader_if main_if ();
  regfile_scan_reader_if sub_if ();

  always #5 clk = ~clk;

  assign rd                = regs[rr];
  assign sub_rd            = regs[sub_rr];
  assign main_if.out_ready = out_ready;
  assign sub_if.out_ready  = out_ready;

  regfile_scan_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .ReadRegister (rr),
    .ReadData     (rd),
    .out_if       (main_if.master),
    .busy         (busy),
    .done         (done)
  );

  regfile_scan_reader #(
    .FIRST_REG      (5),
    .LAST_REG       (7),
    .FORCE_ZERO_X31 (1'b1)
  ) dut_sub (
    .clk          (clk),
    .reset        (reset),
    .start        (sub_start),
    .abort        (abort),
    .ReadRegister (sub_rr),
    .ReadData     (sub_rd),
    .out_if       (sub_if.master),
    .busy         (sub_busy),
    .done         (sub_done)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and drive out_ready for that cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = pat_bits[cyc[1:0]];
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic push_main_range();
    for (int i = 0; i < 32; i++) begin
      beat_t b;
      b.data  = (i == 31) ? 64'h0 : regs[i];
      b.index = 5'(i);
      b.last  = (i == 31);
      q_main.push_back(b);
    end
  endtask

  task automatic apply_stimulus(input bit to_sub);
    if (to_sub) sub_start = 1'b1;
    else start = 1'b1;
    step();
    start     = 1'b0;
    sub_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((busy || sub_busy || q_main.size() != 0 || q_sub.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    if (n >= max_cycles) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
    step();
    step();
  endtask

  // Main monitor: pops the scoreboard on each handshake, checks hold while stalled
  // and that done pulses exactly the cycle after the last beat is accepted.
  logic        exp_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [4:0]  prev_index;
  logic [4:0]  prev_rr;
  always @(negedge clk) begin
    if (!reset) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check_output("done", 64'(done), 64'(exp_done));
      if (done) done_count++;
      exp_done = 1'b0;
      if (prev_stall) begin
        check_output("stall_valid", 64'(main_if.out_valid), 64'h1);
        check_output("stall_data", main_if.out_data, prev_data);
        check_output("stall_index", 64'(main_if.out_index), 64'(prev_index));
        check_output("stall_rr", 64'(rr), 64'(prev_rr));
      end
      if (main_if.out_valid && out_ready) begin
        if (q_main.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_beat: got index %0d, expected no beat", main_if.out_index);
        end else begin
          beat_t e;
          e = q_main.pop_front();
          check_output("beat_data", main_if.out_data, e.data);
          check_output("beat_index", 64'(main_if.out_index), 64'(e.index));
          check_output("beat_last", 64'(main_if.out_last), 64'(e.last));
          exp_done = e.last && !abort;
        end
      end
      prev_stall = main_if.out_valid && !out_ready && !abort;
      prev_data  = main_if.out_data;
      prev_index = main_if.out_index;
      prev_rr    = rr;
    end
  end

  // Sub-range monitor: same scoreboard discipline for the 5..7 instance.
  logic sub_exp_done = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      sub_exp_done = 1'b0;
    end else begin
      check_output("sub_done", 64'(sub_done), 64'(sub_exp_done));
      if (sub_done) sub_done_cnt++;
      sub_exp_done = 1'b0;
      if (sub_if.out_valid && out_ready) begin
        if (q_sub.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL sub_unexpected_beat: got index %0d, expected no beat", sub_if.out_index);
        end else begin
          beat_t e;
          e = q_sub.pop_front();
          check_output("sub_beat_data", sub_if.out_data, e.data);
          check_output("sub_beat_index", 64'(sub_if.out_index), 64'(e.index));
          check_output("sub_beat_last", 64'(sub_if.out_last), 64'(e.last));
          sub_exp_done = e.last && !abort;
        end
      end
    end
  end

  initial begin
    int d0;
    int n;
    bit found;
    reset     = 1'b0;
    start     = 1'b0;
    sub_start = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);

    // Reset state
    #12;
    check_output("rst_valid", 64'(main_if.out_valid), 64'h0);
    check_output("rst_busy", 64'(busy), 64'h0);
    check_output("rst_done", 64'(done), 64'h0);
    check_output("rst_rr", 64'(rr), 64'h0);
    check_output("rst_data", main_if.out_data, 64'h0);
    check_output("rst_index", 64'(main_if.out_index), 64'h0);
    check_output("rst_last", 64'(main_if.out_last), 64'h0);
    check_output("rst_sub_rr", 64'(sub_rr), 64'h5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    check_output("idle_busy", 64'(busy), 64'h0);

    // Test 1: full scan at full throughput
    $display("[TB] test 1: full scan");
    d0 = done_count;
    push_main_range();
    apply_stimulus(1'b0);
    check_output("t1_valid_after_1", 64'(main_if.out_valid), 64'h0);
    check_output("t1_busy_after_1", 64'(busy), 64'h1);
    check_output("t1_rr_after_1", 64'(rr), 64'h0);
    step();
    check_output("t1_valid_after_2", 64'(main_if.out_valid), 64'h1);
    check_output("t1_first_index", 64'(main_if.out_index), 64'h0);
    check_output("t1_first_data", main_if.out_data, 64'h1000);
    check_output("t1_rr_after_2", 64'(rr), 64'h1);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check_output("t1_cycles", 64'(n), 64'd32);
    wait_idle(100);
    check_output("t1_done_count", 64'(done_count - d0), 64'h1);

    // Test 2: backpressure pattern 1,0,0,1
    $display("[TB] test 2: backpressure");
    for (int i = 0; i < 32; i++) regs[i] = 64'hCAFE_0000_0000_0000 + 64'(i) * 64'h0101;
    d0 = done_count;
    ready_mode = 1;
    push_main_range();
    apply_stimulus(1'b0);
    wait_idle(400);
    check_output("t2_done_count", 64'(done_count - d0), 64'h1);
    ready_mode = 0;

    // Test 3: sub-range 5..7
    $display("[TB] test 3: sub-range");
    for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
    d0 = sub_done_cnt;
    for (int i = 5; i <= 7; i++) begin
      beat_t b;
      b.data  = regs[i];
      b.index = 5'(i);
      b.last  = (i == 7);
      q_sub.push_back(b);
    end
    apply_stimulus(1'b1);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (sub_if.out_valid && sub_if.out_index == 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    check_output("t3_saw_last", 64'(found), 64'h1);
    check_output("t3_last_flag", 64'(sub_if.out_last), 64'h1);
    step();
    check_output("t3_busy_fell", 64'(sub_busy), 64'h0);
    check_output("t3_done_high", 64'(sub_done), 64'h1);
    wait_idle(50);
    check_output("t3_done_count", 64'(sub_done_cnt - d0), 64'h1);
    check_output("t3_main_idle", 64'(busy), 64'h0);

    // Test 4: abort at beat 10 while stalled, then rescan
    $display("[TB] test 4: abort");
    d0 = done_count;
    push_main_range();
    apply_stimulus(1'b0);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (main_if.out_valid && main_if.out_index == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    check_output("t4_reached_10", 64'(found), 64'h1);
    out_ready  = 1'b0;
    abort      = 1'b1;
    ready_mode = 2;
    step();
    abort = 1'b0;
    check_output("t4_valid", 64'(main_if.out_valid), 64'h0);
    check_output("t4_busy", 64'(busy), 64'h0);
    check_output("t4_rr", 64'(rr), 64'h0);
    q_main.delete();
    ready_mode = 0;
    step();
    step();
    step();
    check_output("t4_no_done", 64'(done_count - d0), 64'h0);
    d0 = done_count;
    push_main_range();
    apply_stimulus(1'b0);
    wait_idle(100);
    check_output("t4_rescan_done", 64'(done_count - d0), 64'h1);

    // Test 5: start while busy and start coincident with final handshake
    $display("[TB] test 5: ignored starts");
    d0 = done_count;
    push_main_range();
    apply_stimulus(1'b0);
    step();
    step();
    step();
    apply_stimulus(1'b0);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (main_if.out_valid && main_if.out_last) begin
        found = 1'b1;
        break;
      end
    end
    check_output("t5_saw_last", 64'(found), 64'h1);
    apply_stimulus(1'b0);
    check_output("t5_busy_after", 64'(busy), 64'h0);
    wait_idle(100);
    step();
    step();
    check_output("t5_done_count", 64'(done_count - d0), 64'h1);
    check_output("t5_still_idle", 64'(busy), 64'h0);

    // Test 6: asynchronous reset mid-scan
    $display("[TB] test 6: async reset");
    d0 = done_count;
    push_main_range();
    apply_stimulus(1'b0);
    for (int k = 0; k < 5; k++) step();
    #3;
    reset = 1'b0;
    #1;
    check_output("t6_valid", 64'(main_if.out_valid), 64'h0);
    check_output("t6_busy", 64'(busy), 64'h0);
    check_output("t6_rr", 64'(rr), 64'h0);
    check_output("t6_done", 64'(done), 64'h0);
    q_main.delete();
    step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check_output("t6_idle_valid", 64'(main_if.out_valid), 64'h0);
    check_output("t6_idle_busy", 64'(busy), 64'h0);
    check_output("t6_no_done", 64'(done_count - d0), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
